// File: rtl/mu_arbiter.sv
// mu_arbiter: shares the single MemoryUnit bus between the CPU and the DMA
// engine. Each port latches one request at a time, the winner is picked by a
// weighted round-robin that lets the CPU take up to CPU_WEIGHT consecutive
// grants while the DMA waits, and the MemoryUnit start/busy handshake is
// sequenced here so neither master ever sees another's transaction.
module mu_arbiter #(
    parameter int unsigned CPU_WEIGHT = 1,
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              nreset,

    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_we,
    input  logic              cpu_start,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_q,

    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_data,
    input  logic              dma_we,
    input  logic              dma_start,
    output logic              dma_busy,
    output logic [DATA_W-1:0] dma_q,

    output logic [ADDR_W-1:0] mu_address,
    output logic [DATA_W-1:0] mu_data,
    output logic              mu_we,
    output logic              mu_start,
    input  logic              mu_busy,
    input  logic [DATA_W-1:0] mu_q,

    output logic              grant_dma
);

    // Streak counter is 4 bits, enough for the 1..15 weight range.
    localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-port request holding registers and pending flags.
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_data;
    logic              cpu_req_we;
    logic              cpu_pend;

    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_data;
    logic              dma_req_we;
    logic              dma_pend;

    // Arbitration history: who was granted last and how many CPU grants in a row.
    logic       last_dma;
    logic [3:0] cpu_streak;

    // FSM strobes.
    logic load;
    logic done;
    logic sel_dma;

    // A new request is accepted only when that port has nothing outstanding.
    logic cpu_accept;
    logic dma_accept;

    assign cpu_accept = cpu_start && !cpu_pend;
    assign dma_accept = dma_start && !dma_pend;

    // The pending flag already covers "waiting" and "in service", since it is
    // only cleared when the winner's transaction completes.
    assign cpu_busy = cpu_pend;
    assign dma_busy = dma_pend;

    assign mu_start  = (state == S_ISSUE);
    assign grant_dma = last_dma && (state != S_IDLE);

    // Winner selection: a lone requester always wins; on a tie the DMA only
    // wins once the CPU has used up its streak allowance.
    always_comb begin
        sel_dma = 1'b0;
        if (dma_pend && !cpu_pend) begin
            sel_dma = 1'b1;
        end else if (dma_pend && cpu_pend) begin
            sel_dma = !last_dma && (cpu_streak >= WEIGHT);
        end
    end

    // Next-state logic for the MemoryUnit handshake sequencer.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_pend || dma_pend) begin
                    load      = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mu_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!mu_busy) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any in-flight MemoryUnit access.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request field capture; the requester may drop its fields after the pulse.
    always_ff @(posedge clk) begin
        if (cpu_accept) begin
            cpu_req_addr <= cpu_address;
            cpu_req_data <= cpu_data;
            cpu_req_we   <= cpu_we;
        end
        if (dma_accept) begin
            dma_req_addr <= dma_address;
            dma_req_data <= dma_data;
            dma_req_we   <= dma_we;
        end
    end

    // Pending flags: set on an accepted start, cleared when that port's
    // transaction completes. A start on the completion cycle still sees the
    // flag set and is dropped, which keeps the two events from colliding.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cpu_pend <= 1'b0;
            dma_pend <= 1'b0;
        end else begin
            if (cpu_accept) begin
                cpu_pend <= 1'b1;
            end else if (done && !last_dma) begin
                cpu_pend <= 1'b0;
            end
            if (dma_accept) begin
                dma_pend <= 1'b1;
            end else if (done && last_dma) begin
                dma_pend <= 1'b0;
            end
        end
    end

    // Grant history: last winner doubles as the current bus owner, and the
    // CPU streak saturates at the weight so the tie rule stays simple.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_dma   <= 1'b1;
            cpu_streak <= 4'd0;
        end else if (load) begin
            last_dma <= sel_dma;
            if (sel_dma) begin
                cpu_streak <= 4'd0;
            end else if (cpu_streak < WEIGHT) begin
                cpu_streak <= cpu_streak + 4'd1;
            end
        end
    end

    // Bus drive registers: loaded from the winner in IDLE and then held
    // untouched through the whole transaction and the following idle period.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mu_address <= '0;
            mu_data    <= '0;
            mu_we      <= 1'b0;
        end else if (load) begin
            if (sel_dma) begin
                mu_address <= dma_req_addr;
                mu_data    <= dma_req_data;
                mu_we      <= dma_req_we;
            end else begin
                mu_address <= cpu_req_addr;
                mu_data    <= cpu_req_data;
                mu_we      <= cpu_req_we;
            end
        end
    end

    // Read-data return: the owner's q is refreshed on every completion,
    // writes included, and otherwise holds the previous result.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cpu_q <= '0;
            dma_q <= '0;
        end else if (done) begin
            if (last_dma) begin
                dma_q <= mu_q;
            end else begin
                cpu_q <= mu_q;
            end
        end
    end

endmodule

// File: tb/tb_mu_arbiter.sv
// Directed testbench for mu_arbiter with a small MemoryUnit model.
module tb_mu_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic [26:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_we;
    logic        cpu_start;
    logic        cpu_busy;
    logic [31:0] cpu_q;
    logic [26:0] dma_address;
    logic [31:0] dma_data;
    logic        dma_we;
    logic        dma_start;
    logic        dma_busy;
    logic [31:0] dma_q;
    logic [26:0] mu_address;
    logic [31:0] mu_data;
    logic        mu_we;
    logic        mu_start;
    logic        mu_busy = 1'b0;
    logic [31:0] mu_q = 32'h0;
    logic        grant_dma;

    int checks = 0;
    int errors = 0;

    // MemoryUnit model state
    int          busy_len = 1;
    logic [31:0] mq_base  = 32'h0;
    int          mcnt     = 0;
    int          n_starts = 0;
    logic        log_dma  [0:63];
    logic [26:0] log_addr [0:63];

    mu_arbiter #(.CPU_WEIGHT(3)) dut (
        .clk(clk), .nreset(nreset),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_we(cpu_we),
        .cpu_start(cpu_start), .cpu_busy(cpu_busy), .cpu_q(cpu_q),
        .dma_address(dma_address), .dma_data(dma_data), .dma_we(dma_we),
        .dma_start(dma_start), .dma_busy(dma_busy), .dma_q(dma_q),
        .mu_address(mu_address), .mu_data(mu_data), .mu_we(mu_we),
        .mu_start(mu_start), .mu_busy(mu_busy), .mu_q(mu_q),
        .grant_dma(grant_dma)
    );

    always #5 clk = ~clk;

    // MemoryUnit: busy for busy_len cycles after a start, read data = mq_base.
    always @(posedge clk) begin
        if (mu_start) begin
            mu_busy <= 1'b1;
            mcnt    <= busy_len;
            mu_q    <= mq_base;
            if (n_starts < 64) begin
                log_dma[n_starts]  <= grant_dma;
                log_addr[n_starts] <= mu_address;
            end
            n_starts <= n_starts + 1;
        end else if (mu_busy) begin
            if (mcnt <= 1) mu_busy <= 1'b0;
            mcnt <= mcnt - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60 && (cpu_busy || dma_busy); k++) tick();
        checks++;
        if (cpu_busy || dma_busy) begin
            errors++;
            $display("FAIL %s_timeout: cpu_busy=%0b dma_busy=%0b, required both 0", tag, cpu_busy, dma_busy);
        end
    endtask

    task automatic req_cpu(input logic [26:0] a);
        cpu_address = a; cpu_we = 1'b0; cpu_data = 32'h0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
    endtask

    task automatic req_both(input logic [26:0] ca, input logic [26:0] da);
        cpu_address = ca; cpu_we = 1'b0; cpu_start = 1'b1;
        dma_address = da; dma_we = 1'b0; dma_start = 1'b1;
        tick();
        cpu_start = 1'b0; dma_start = 1'b0;
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        cpu_address = '0; cpu_data = '0; cpu_we = 1'b0; cpu_start = 1'b0;
        dma_address = '0; dma_data = '0; dma_we = 1'b0; dma_start = 1'b0;
        repeat (3) tick();
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_cpu_busy: got %b want 0", cpu_busy); end
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL rst_dma_busy: got %b want 0", dma_busy); end
        checks++; if (cpu_q !== 32'h0) begin errors++; $display("FAIL rst_cpu_q: got %h want 0", cpu_q); end
        checks++; if (dma_q !== 32'h0) begin errors++; $display("FAIL rst_dma_q: got %h want 0", dma_q); end
        checks++; if (mu_address !== 27'h0) begin errors++; $display("FAIL rst_mu_address: got %h want 0", mu_address); end
        checks++; if (mu_data !== 32'h0) begin errors++; $display("FAIL rst_mu_data: got %h want 0", mu_data); end
        checks++; if (mu_we !== 1'b0) begin errors++; $display("FAIL rst_mu_we: got %b want 0", mu_we); end
        checks++; if (mu_start !== 1'b0) begin errors++; $display("FAIL rst_mu_start: got %b want 0", mu_start); end
        checks++; if (grant_dma !== 1'b0) begin errors++; $display("FAIL rst_grant_dma: got %b want 0", grant_dma); end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        busy_len = 1; mq_base = 32'hDEADBEEF;
        req_cpu(27'h0000123);                                 // now cycle 1
        checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL sr_busy_c1: got %b want 1", cpu_busy); end
        checks++; if (mu_start !== 1'b0) begin errors++; $display("FAIL sr_start_c1: got %b want 0", mu_start); end
        tick();                                               // cycle 2
        checks++; if (mu_start !== 1'b1) begin errors++; $display("FAIL sr_start_c2: got %b want 1", mu_start); end
        checks++; if (mu_address !== 27'h0000123) begin errors++; $display("FAIL sr_addr: got %h want 0000123", mu_address); end
        checks++; if (mu_we !== 1'b0) begin errors++; $display("FAIL sr_we: got %b want 0", mu_we); end
        checks++; if (grant_dma !== 1'b0) begin errors++; $display("FAIL sr_grant: got %b want 0", grant_dma); end
        tick();                                               // cycle 3
        checks++; if (mu_start !== 1'b0) begin errors++; $display("FAIL sr_start_c3: got %b want 0", mu_start); end
        tick();                                               // cycle 4
        checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL sr_busy_c4: got %b want 1", cpu_busy); end
        tick();                                               // cycle 5
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL sr_busy_c5: got %b want 0", cpu_busy); end
        checks++; if (cpu_q !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_cpu_q: got %h want deadbeef", cpu_q); end
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL sr_dma_busy: got %b want 0", dma_busy); end
    endtask

    task automatic test_simultaneous;
        busy_len = 1; mq_base = 32'h11111111;
        req_both(27'h0000010, 27'h0000020);                   // cycle 1
        checks++; if ({cpu_busy, dma_busy} !== 2'b11) begin errors++; $display("FAIL sim_busy_c1: got %b want 11", {cpu_busy, dma_busy}); end
        tick();                                               // cycle 2
        checks++; if (mu_start !== 1'b1 || mu_address !== 27'h10) begin errors++; $display("FAIL sim_cpu_issue: start=%b addr=%h want 1/010", mu_start, mu_address); end
        checks++; if (grant_dma !== 1'b0) begin errors++; $display("FAIL sim_grant_cpu: got %b want 0", grant_dma); end
        repeat (3) tick();                                    // cycle 5
        checks++; if (cpu_busy !== 1'b0 || cpu_q !== 32'h11111111) begin errors++; $display("FAIL sim_cpu_done: busy=%b q=%h want 0/11111111", cpu_busy, cpu_q); end
        checks++; if (dma_busy !== 1'b1) begin errors++; $display("FAIL sim_dma_wait: got %b want 1", dma_busy); end
        mq_base = 32'h22222222;
        tick();                                               // cycle 6
        checks++; if (mu_start !== 1'b1 || mu_address !== 27'h20) begin errors++; $display("FAIL sim_dma_issue: start=%b addr=%h want 1/020", mu_start, mu_address); end
        checks++; if (grant_dma !== 1'b1) begin errors++; $display("FAIL sim_grant_dma: got %b want 1", grant_dma); end
        tick();                                               // cycle 7
        checks++; if (grant_dma !== 1'b1) begin errors++; $display("FAIL sim_grant_hold: got %b want 1", grant_dma); end
        repeat (2) tick();                                    // cycle 9
        checks++; if (dma_busy !== 1'b0 || dma_q !== 32'h22222222) begin errors++; $display("FAIL sim_dma_done: busy=%b q=%h want 0/22222222", dma_busy, dma_q); end
        checks++; if (cpu_q !== 32'h11111111) begin errors++; $display("FAIL sim_cpu_q_hold: got %h want 11111111", cpu_q); end
        checks++; if (grant_dma !== 1'b0) begin errors++; $display("FAIL sim_grant_idle: got %b want 0", grant_dma); end
    endtask

    task automatic test_weight;
        int base;
        logic [8:0] exp_order;
        logic [8:0] got_order;
        busy_len = 1;
        exp_order = 9'b010001000;   // bit i = 1 when start i went to the DMA
        base = n_starts;
        req_cpu(27'h1); wait_idle("w1");
        req_cpu(27'h2); wait_idle("w2");
        req_both(27'h3, 27'h4); wait_idle("w3");
        req_cpu(27'h5); wait_idle("w4");
        req_cpu(27'h6); wait_idle("w5");
        req_cpu(27'h7); wait_idle("w6");
        req_both(27'h8, 27'h9); wait_idle("w7");
        tick();
        checks++; if (n_starts - base !== 9) begin errors++; $display("FAIL w_count: got %0d starts want 9", n_starts - base); end
        got_order = '0;
        for (int i = 0; i < 9; i++) got_order[i] = log_dma[base + i];
        checks++; if (got_order !== exp_order) begin errors++; $display("FAIL w_order: got %b want %b", got_order, exp_order); end
    endtask

    task automatic test_dma_write;
        busy_len = 3; mq_base = 32'h0BADF00D;
        dma_address = 27'h0ABCDEF; dma_data = 32'hA5A5A5A5; dma_we = 1'b1; dma_start = 1'b1;
        tick();                                               // cycle 1
        dma_start = 1'b0; dma_address = 27'h7FFFFFF; dma_data = 32'h0; dma_we = 1'b0;
        checks++; if (dma_busy !== 1'b1) begin errors++; $display("FAIL dw_busy: got %b want 1", dma_busy); end
        tick();                                               // cycle 2
        checks++; if (mu_start !== 1'b1 || mu_data !== 32'hA5A5A5A5 || mu_we !== 1'b1 || mu_address !== 27'h0ABCDEF)
            begin errors++; $display("FAIL dw_issue: start=%b data=%h we=%b addr=%h want 1/a5a5a5a5/1/0abcdef", mu_start, mu_data, mu_we, mu_address); end
        for (int k = 0; k < 20 && dma_busy; k++) begin
            tick();
            if (dma_busy) begin
                checks++;
                if (mu_data !== 32'hA5A5A5A5 || mu_we !== 1'b1 || grant_dma !== 1'b1)
                    begin errors++; $display("FAIL dw_stable: data=%h we=%b grant=%b want a5a5a5a5/1/1", mu_data, mu_we, grant_dma); end
            end
        end
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL dw_timeout: dma_busy=%b want 0", dma_busy); end
        checks++; if (mu_data !== 32'hA5A5A5A5 || dma_q !== 32'h0BADF00D) begin errors++; $display("FAIL dw_after: data=%h q=%h want a5a5a5a5/0badf00d", mu_data, dma_q); end
    endtask

    task automatic test_ignore;
        int base;
        busy_len = 1; mq_base = 32'h12345678;
        base = n_starts;
        cpu_address = 27'h100; cpu_we = 1'b0; cpu_start = 1'b1;
        tick();                                               // cycle 1, start still high
        cpu_address = 27'h200;
        tick();                                               // cycle 2
        cpu_start = 1'b0;
        checks++; if (mu_address !== 27'h100) begin errors++; $display("FAIL ig_addr: got %h want 100", mu_address); end
        tick();                                               // cycle 3
        cpu_address = 27'h300; cpu_start = 1'b1;
        tick();                                               // cycle 4, completion cycle
        cpu_address = 27'h400;
        checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL ig_busy_c4: got %b want 1", cpu_busy); end
        tick();                                               // cycle 5
        cpu_start = 1'b0;
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL ig_busy_c5: got %b want 0", cpu_busy); end
        repeat (3) tick();
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL ig_busy_late: got %b want 0", cpu_busy); end
        checks++; if (n_starts - base !== 1) begin errors++; $display("FAIL ig_count: got %0d starts want 1", n_starts - base); end
        checks++; if (log_addr[base] !== 27'h100) begin errors++; $display("FAIL ig_logaddr: got %h want 100", log_addr[base]); end
    endtask

    task automatic test_reset_mid;
        busy_len = 4; mq_base = 32'h5555AAAA;
        req_cpu(27'h77);
        repeat (3) tick();                                    // cycle 4, WAIT_DONE
        checks++; if (cpu_busy !== 1'b1 || mu_busy !== 1'b1) begin errors++; $display("FAIL rm_inflight: cpu_busy=%b mu_busy=%b want 1/1", cpu_busy, mu_busy); end
        #2 nreset = 1'b0;
        #1;
        checks++; if (cpu_busy !== 1'b0 || dma_busy !== 1'b0 || grant_dma !== 1'b0 || mu_start !== 1'b0)
            begin errors++; $display("FAIL rm_ctrl: cpu_busy=%b dma_busy=%b grant=%b start=%b want 0000", cpu_busy, dma_busy, grant_dma, mu_start); end
        checks++; if (mu_address !== 27'h0 || mu_data !== 32'h0 || mu_we !== 1'b0 || cpu_q !== 32'h0 || dma_q !== 32'h0)
            begin errors++; $display("FAIL rm_data: addr=%h data=%h we=%b cq=%h dq=%h want all 0", mu_address, mu_data, mu_we, cpu_q, dma_q); end
        #2 nreset = 1'b1;
        for (int k = 0; k < 20 && mu_busy; k++) tick();
        tick();
        busy_len = 1; mq_base = 32'h600DF00D;
        req_cpu(27'h99);
        tick();                                               // cycle 2
        checks++; if (mu_start !== 1'b1 || mu_address !== 27'h99) begin errors++; $display("FAIL rm_issue: start=%b addr=%h want 1/099", mu_start, mu_address); end
        repeat (3) tick();                                    // cycle 5
        checks++; if (cpu_busy !== 1'b0 || cpu_q !== 32'h600DF00D) begin errors++; $display("FAIL rm_done: busy=%b q=%h want 0/600df00d", cpu_busy, cpu_q); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_weight();
        test_dma_write();
        test_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
